// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch and halfword-alignment stage.
// Issues word-aligned reads to instruction RAM (1-cycle read latency), buffers
// returned halfwords in a 4-entry queue and presents one aligned 32-bit or
// compressed 16-bit instruction with its PC under a valid/ready handshake.
// A redirect flushes the queue and restarts fetch at the target.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   iram_rd_en_o/addr_o   read strobe and word-aligned byte address
//   iram_rd_data_i        read data, valid the cycle after iram_rd_en_o
//   redirect_i/pc_i       flush and restart at redirect_pc_i (bit0 ignored)
//   inst_valid_o/ready_i  instruction handshake
//   inst_data_o, pc_o     instruction (compressed = {16'h0, hw}) and its PC
module inst_fetch #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   output logic            iram_rd_en_o,
   output logic [XLEN-1:0] iram_rd_addr_o,
   input  logic [XLEN-1:0] iram_rd_data_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            inst_valid_o,
   input  logic            inst_ready_i,
   output logic [XLEN-1:0] inst_data_o,
   output logic [XLEN-1:0] pc_o
);

   localparam int unsigned HW_W  = 16;
   localparam int unsigned QD    = 4;
   localparam int unsigned CNT_W = 3;

   localparam logic [0:0] ST_BOOT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);
   localparam logic [XLEN-1:0] HALF_MASK = ~XLEN'(1);

   logic [0:0]       state, state_nxt;
   logic [HW_W-1:0]  q     [QD];
   logic [HW_W-1:0]  q_nxt [QD];
   logic [CNT_W-1:0] count, count_nxt;
   logic             rd_pending, rd_pending_nxt;
   logic             drop_low, drop_low_nxt;
   logic [XLEN-1:0]  fetch_addr, fetch_addr_nxt;
   logic [XLEN-1:0]  pc, pc_nxt;

   logic             is_comp_c;
   logic             valid_c;
   logic [XLEN-1:0]  data_c;
   logic             rd_en_c;
   logic             consume_c;
   logic             push_c;
   logic [CNT_W-1:0] pop_len_c;
   logic [CNT_W-1:0] pop_n_c;
   logic [CNT_W-1:0] push_len_c;
   logic [CNT_W-1:0] base_c;
   logic [CNT_W-1:0] occupancy_c;

   // Next-state, queue update and handshake logic
   always_comb begin
      state_nxt      = state;
      count_nxt      = count;
      rd_pending_nxt = rd_pending;
      drop_low_nxt   = drop_low;
      fetch_addr_nxt = fetch_addr;
      pc_nxt         = pc;
      for (int i = 0; i < QD; i++) q_nxt[i] = q[i];

      if (state == ST_BOOT) state_nxt = ST_RUN;

      // Instruction length is decided by the oldest halfword alone
      is_comp_c = (q[0][1:0] != 2'b11);
      pop_len_c = is_comp_c ? CNT_W'(1) : CNT_W'(2);
      valid_c   = is_comp_c ? (count >= CNT_W'(1)) : (count >= CNT_W'(2));
      data_c    = is_comp_c ? XLEN'(q[0]) : XLEN'({q[1], q[0]});

      // Slots already owed to an in-flight read count as occupied
      occupancy_c = count + (rd_pending ? CNT_W'(2) : CNT_W'(0));
      rd_en_c     = (state == ST_RUN) && !redirect_i && (occupancy_c <= CNT_W'(2));

      consume_c  = valid_c && inst_ready_i && !redirect_i;
      push_c     = rd_pending && !redirect_i;
      push_len_c = drop_low ? CNT_W'(1) : CNT_W'(2);
      pop_n_c    = consume_c ? pop_len_c : CNT_W'(0);
      base_c     = count - pop_n_c;

      // Pop: shift surviving halfwords towards slot 0
      if (pop_n_c == CNT_W'(1)) begin
         for (int i = 0; i < QD - 1; i++) q_nxt[i] = q[i + 1];
      end else if (pop_n_c == CNT_W'(2)) begin
         for (int i = 0; i < QD - 2; i++) q_nxt[i] = q[i + 2];
      end

      // Push: append after the survivors; drop_low skips the low half
      if (push_c) begin
         for (int i = 0; i < QD; i++) begin
            if (drop_low) begin
               if (CNT_W'(i) == base_c) q_nxt[i] = iram_rd_data_i[2*HW_W-1:HW_W];
            end else begin
               if (CNT_W'(i) == base_c)             q_nxt[i] = iram_rd_data_i[HW_W-1:0];
               if (CNT_W'(i) == base_c + CNT_W'(1)) q_nxt[i] = iram_rd_data_i[2*HW_W-1:HW_W];
            end
         end
         drop_low_nxt = 1'b0;
      end

      count_nxt      = base_c + (push_c ? push_len_c : CNT_W'(0));
      // A response arrives exactly one cycle after issue, so pending is just last cycle's issue
      rd_pending_nxt = rd_en_c;
      if (rd_en_c)   fetch_addr_nxt = fetch_addr + XLEN'(4);
      if (consume_c) pc_nxt = pc + XLEN'({pop_len_c, 1'b0});

      // Redirect wins over consume and push; any arriving response is dropped
      if (redirect_i) begin
         count_nxt      = '0;
         rd_pending_nxt = 1'b0;
         pc_nxt         = redirect_pc_i & HALF_MASK;
         fetch_addr_nxt = redirect_pc_i & WORD_MASK;
         drop_low_nxt   = redirect_pc_i[1];
      end
   end

   // State registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= ST_BOOT;
         count      <= '0;
         rd_pending <= 1'b0;
         drop_low   <= 1'b0;
         fetch_addr <= RESET_PC & WORD_MASK;
         pc         <= RESET_PC;
         for (int i = 0; i < QD; i++) q[i] <= '0;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         rd_pending <= rd_pending_nxt;
         drop_low   <= drop_low_nxt;
         fetch_addr <= fetch_addr_nxt;
         pc         <= pc_nxt;
         for (int i = 0; i < QD; i++) q[i] <= q_nxt[i];
      end
   end

   assign iram_rd_en_o   = rd_en_c;
   assign iram_rd_addr_o = fetch_addr;
   assign inst_valid_o   = valid_c;
   assign inst_data_o    = data_c;
   assign pc_o           = pc;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: self-checking bench for inst_fetch.
// A 1-cycle-latency RAM model serves reads; a reference model walks the
// instruction stream straight from memory contents (pc, halfword length)
// and is checked against every instruction the DUT hands over.
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_en;
   logic [31:0] rd_addr;
   logic [31:0] rd_data = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        valid;
   logic        ready = 1'b0;
   logic [31:0] data;
   logic [31:0] pc;

   logic [31:0] mem [256];

   int          n_vec = 0;
   int          n_err = 0;

   logic [31:0] exp_pc, exp_fetch;
   logic        hold_valid;
   logic [31:0] hold_pc, hold_data;
   int          idle;
   logic        prev_rd_en;
   logic [31:0] acc_pc[$];
   logic [31:0] acc_inst[$];

   logic        drv_ready = 1'b0;
   logic        drv_redirect = 1'b0;
   logic [31:0] drv_target = '0;
   logic        sim_arm = 1'b0;
   logic        sim_hit = 1'b0;
   logic [31:0] sim_target = '0;

   logic        s_valid, s_rd_en;
   logic [31:0] s_pc, s_data, s_addr;

   inst_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .iram_rd_en_o   (rd_en),
      .iram_rd_addr_o (rd_addr),
      .iram_rd_data_i (rd_data),
      .redirect_i     (redirect),
      .redirect_pc_i  (redirect_pc),
      .inst_valid_o   (valid),
      .inst_ready_i   (ready),
      .inst_data_o    (data),
      .pc_o           (pc)
   );

   always #5 clk = ~clk;

   // Instruction RAM: data appears the cycle after the strobe
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr[9:2]];
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] hw_at(input logic [31:0] a);
      logic [31:0] w;
      w = mem[a[9:2]];
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   function automatic logic [31:0] inst_at(input logic [31:0] a);
      logic [15:0] h0;
      h0 = hw_at(a);
      if (h0[1:0] != 2'b11) return {16'h0, h0};
      return {hw_at(a + 32'd2), h0};
   endfunction

   function automatic logic [31:0] len_at(input logic [31:0] a);
      logic [15:0] h0;
      h0 = hw_at(a);
      return (h0[1:0] != 2'b11) ? 32'd2 : 32'd4;
   endfunction

   // One clock cycle: drive at negedge, sample 1 time unit later, score, advance model
   task automatic step();
      @(negedge clk);
      if (sim_arm && valid && prev_rd_en && drv_ready) begin
         drv_redirect = 1'b1;
         drv_target   = sim_target;
         sim_arm      = 1'b0;
         sim_hit      = 1'b1;
      end
      ready       = drv_ready;
      redirect    = drv_redirect;
      redirect_pc = drv_target;
      #1;
      s_valid = valid; s_pc = pc; s_data = data; s_rd_en = rd_en; s_addr = rd_addr;

      if (hold_valid) begin
         check("stall_valid", 32'(s_valid), 32'd1);
         check("stall_pc", s_pc, hold_pc);
         check("stall_inst", s_data, hold_data);
      end
      if (s_valid) begin
         check("pc", s_pc, exp_pc);
         check("inst", s_data, inst_at(exp_pc));
      end
      if (s_rd_en) check("rd_addr", s_addr, exp_fetch);

      if (redirect) begin
         exp_pc     = drv_target & ~32'd1;
         exp_fetch  = drv_target & ~32'd3;
         hold_valid = 1'b0;
         idle       = 0;
      end else begin
         if (s_rd_en) exp_fetch = exp_fetch + 32'd4;
         if (s_valid && ready) begin
            acc_pc.push_back(s_pc);
            acc_inst.push_back(s_data);
            exp_pc = exp_pc + len_at(exp_pc);
            idle   = 0;
         end else if (ready) begin
            idle++;
            if (idle > 12) begin
               check("progress", 32'(idle), 32'd0);
               idle = 0;
            end
         end
         hold_valid = s_valid && !ready;
         hold_pc    = s_pc;
         hold_data  = s_data;
      end
      prev_rd_en = s_rd_en;
   endtask

   // Entered with rst_n low: check reset outputs, release, check the boot sequence
   task automatic boot_seq(input logic [31:0] first_inst);
      #1;
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_rd_en", 32'(rd_en), 32'd0);
      check("rst_pc", pc, RESET_PC);
      check("rst_inst", data, 32'd0);
      drv_ready = 1'b0; drv_redirect = 1'b0; ready = 1'b0; redirect = 1'b0;
      exp_pc     = RESET_PC;
      exp_fetch  = RESET_PC & ~32'd3;
      hold_valid = 1'b0;
      idle       = 0;
      prev_rd_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("boot_rd_en", 32'(s_rd_en), 32'd1);
      check("boot_addr", s_addr, RESET_PC & ~32'd3);
      step();
      check("boot_gap", 32'(s_valid), 32'd0);
      step();
      check("boot_valid", 32'(s_valid), 32'd1);
      check("boot_inst", s_data, first_inst);
      check("boot_pc", s_pc, RESET_PC);
   endtask

   initial begin
      logic found;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;

      // Boot
      mem[0] = 32'h0050_0093;
      repeat (2) @(negedge clk);
      boot_seq(32'h0050_0093);

      // Mixed lengths
      @(negedge clk); rst_n = 1'b0;
      mem[0] = 32'h0093_4505;
      mem[1] = 32'h0000_0050;
      mem[2] = 32'h0001_0001;
      boot_seq(32'h0000_4505);
      acc_pc.delete(); acc_inst.delete();
      drv_ready = 1'b1;
      repeat (8) step();
      check("mixed_n", 32'(acc_pc.size() >= 3), 32'd1);
      if (acc_pc.size() >= 3) begin
         check("mixed_pc0", acc_pc[0], 32'h0);
         check("mixed_i0", acc_inst[0], 32'h0000_4505);
         check("mixed_pc1", acc_pc[1], 32'h2);
         check("mixed_i1", acc_inst[1], 32'h0050_0093);
         check("mixed_pc2", acc_pc[2], 32'h6);
      end

      // Redirect with the read of 0x8 in flight
      @(negedge clk); rst_n = 1'b0;
      mem[64] = 32'h1234_0001;
      boot_seq(32'h0000_4505);
      drv_ready = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (s_rd_en && s_addr == 32'h8) found = 1'b1;
      end
      check("c_issue8", 32'(found), 32'd1);
      drv_redirect = 1'b1; drv_target = 32'h0000_0102;
      step();
      check("c_rd_block", 32'(s_rd_en), 32'd0);
      drv_redirect = 1'b0;
      step();
      check("c_rd_en", 32'(s_rd_en), 32'd1);
      check("c_addr", s_addr, 32'h100);
      check("c_valid0", 32'(s_valid), 32'd0);
      step();
      check("c_valid1", 32'(s_valid), 32'd0);
      step();
      check("c_valid2", 32'(s_valid), 32'd1);
      check("c_pc", s_pc, 32'h102);
      check("c_inst", s_data, 32'h0000_1234);

      // Backpressure, then drain
      drv_ready = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k >= 6) check("d_rd_idle", 32'(s_rd_en), 32'd0);
      end
      drv_ready = 1'b1;
      repeat (20) step();

      // Redirect coinciding with a consume and an arriving response
      sim_target = 32'h0000_0200; sim_hit = 1'b0; sim_arm = 1'b1;
      for (int k = 0; k < 60 && !sim_hit; k++) step();
      sim_arm = 1'b0;
      drv_redirect = 1'b0;
      check("e_hit", 32'(sim_hit), 32'd1);
      if (sim_hit) begin
         step();
         check("e_pc", s_pc, 32'h200);
         check("e_valid", 32'(s_valid), 32'd0);
         check("e_rd_en", 32'(s_rd_en), 32'd1);
         check("e_addr", s_addr, 32'h200);
      end
      repeat (10) step();

      // Address wrap past the top of memory
      drv_redirect = 1'b1; drv_target = 32'hFFFF_FFFA;
      step();
      drv_redirect = 1'b0;
      repeat (16) step();

      // Randomized traffic
      for (int k = 0; k < 2500; k++) begin
         drv_ready    = ($urandom_range(0, 3) != 0);
         drv_redirect = ($urandom_range(0, 31) == 0);
         drv_target   = ($urandom_range(0, 3) == 0) ? {28'hFFFF_FFF, 4'($urandom)} : $urandom;
         step();
      end
      drv_redirect = 1'b0;

      // Asynchronous reset between edges, then the boot sequence again
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      boot_seq(32'h0000_4505);
      drv_ready = 1'b1;
      repeat (10) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
